counter_seq_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the 8-bit loadable up/down counter and drives its Load, In, E and D inputs. On a Start request it latches a preset, a limit and a direction, loads the counter, enables counting until the counter output Q equals the limit, and then either reports completion or reloads for another pass. The counter's Q is fed back into this block, closing the loop. Callers see a simple Start/Busy/Done interface, plus a pass count for auto-reload runs.

---
 rtl/counter_seq_ctrl_if.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 84 ++++++++
 tb/tb_counter_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// Caller- and counter-facing signal bundle for counter_seq_ctrl.
// slave = the controller; master = whoever drives Start/Preset/etc. and closes the Q loop.
interface counter_seq_ctrl_if;
    logic       Start;
    logic       Stop;
    logic       Dir;
    logic       Rep;
    logic [7:0] Preset;
    logic [7:0] Limit;
    logic [7:0] Q;
    logic       Load;
    logic [7:0] In;
    logic       E;
    logic       D;
    logic       Busy;
    logic       Done;
    logic [7:0] Passes;

    modport slave (
        input  Start, Stop, Dir, Rep, Preset, Limit, Q,
        output Load, In, E, D, Busy, Done, Passes
    );

    modport master (
        output Start, Stop, Dir, Rep, Preset, Limit, Q,
        input  Load, In, E, D, Busy, Done, Passes
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an 8-bit loadable up/down counter: load preset, count to limit,
// then finish or reload; Q is fed back to decide when to stop enabling.
module counter_seq_ctrl (
    input  logic               Clk,
    input  logic               Rst_n,
    counter_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] preset_reg, limit_reg, passes_reg;
    logic       dir_reg, rep_reg;
    logic       match;
    logic       load_c, en_c, busy_c, done_c;

    assign match = (bus.Q == limit_reg);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            preset_reg <= 8'd0;
            limit_reg  <= 8'd0;
            dir_reg    <= 1'b0;
            rep_reg    <= 1'b0;
            passes_reg <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.Start) begin
                preset_reg <= bus.Preset;
                limit_reg  <= bus.Limit;
                dir_reg    <= bus.Dir;
                rep_reg    <= bus.Rep;
                passes_reg <= 8'd0;
            end else if (state == RUN && !bus.Stop && match && passes_reg != 8'hFF) begin
                passes_reg <= passes_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        en_c      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) state_nxt = LOAD;
            end
            LOAD: begin
                load_c    = 1'b1;
                busy_c    = 1'b1;
                state_nxt = bus.Stop ? IDLE : RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                // Enable drops the same cycle Q hits the limit, so the counter never overshoots.
                en_c   = !match;
                if (bus.Stop)  state_nxt = IDLE;
                else if (match) state_nxt = rep_reg ? LOAD : DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Load   = load_c;
    assign bus.E      = en_c;
    assign bus.Busy   = busy_c;
    assign bus.Done   = done_c;
    assign bus.In     = preset_reg;
    assign bus.D      = dir_reg;
    assign bus.Passes = passes_reg;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench: a behavioural counter closes the Q loop; expected pass/done
// events are computed from step counts and checked by a free-running monitor.
module tb_counter_seq_ctrl;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    counter_seq_ctrl_if bus ();

    counter_seq_ctrl dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Environment: the loadable up/down counter this block drives.
    logic [7:0] cnt_q = 8'd0;
    always @(posedge Clk) begin
        if (bus.Load)   cnt_q <= bus.In;
        else if (bus.E) cnt_q <= bus.D ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end
    assign bus.Q = cnt_q;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t pass_q[$];
    exp_t done_q[$];
    exp_t me;

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0] cur_preset = 8'd0;
    logic [7:0] cur_limit  = 8'd0;
    logic       cur_dir    = 1'b0;
    bit         chk_en     = 1'b0;
    logic [7:0] prev_p     = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT reports a pass or a completion.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (bus.Passes != prev_p && bus.Passes != 8'd0) begin
                if (pass_q.size() == 0) begin
                    check("unexpected_pass", bus.Passes, prev_p);
                end else begin
                    me = pass_q.pop_front();
                    check("pass_val", bus.Passes, me.val);
                    check("pass_cyc", cyc, me.cyc);
                end
            end
            prev_p = bus.Passes;
            if (bus.Done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", bus.Done, 0);
                end else begin
                    me = done_q.pop_front();
                    check("done_cyc", cyc, me.cyc);
                    check("done_passes", bus.Passes, me.val);
                    check("done_q_at_limit", bus.Q, cur_limit);
                end
            end
            if (chk_en) begin
                check("enable", bus.E, (bus.Busy && !bus.Load && bus.Q != cur_limit) ? 1 : 0);
                if (bus.Busy) begin
                    check("in_latched", bus.In, cur_preset);
                    check("dir_latched", bus.D, cur_dir);
                end
            end
        end
    end

    // One accepted Start; stop_k > 0 issues Stop so that it is sampled stop_k edges after e0.
    task automatic run(input logic [7:0] pre, input logic [7:0] lim, input logic dir,
                       input logic rep, input int stop_k, input bit inject);
        int n, e0, es, pmax, fin;
        logic [7:0] d;
        logic [7:0] pv;
        d  = dir ? (lim - pre) : (pre - lim);
        n  = d;
        @(posedge Clk); #1;
        bus.Start  = 1'b1;
        bus.Preset = pre;
        bus.Limit  = lim;
        bus.Dir    = dir;
        bus.Rep    = rep;
        e0  = cyc + 1;
        es  = e0 + stop_k;
        fin = 0;
        if (!rep) begin
            pass_q.push_back('{e0 + n + 2, 8'd1});
            done_q.push_back('{e0 + n + 2, 8'd1});
        end else begin
            pmax = (stop_k - 1) / (n + 2);
            for (int p = 1; p <= pmax && p <= 255; p++) begin
                pv = p[7:0];
                pass_q.push_back('{e0 + p * (n + 2), pv});
            end
            fin = (pmax > 255) ? 255 : pmax;
        end
        @(posedge Clk); #1;
        bus.Start  = 1'b0;
        cur_preset = pre;
        cur_limit  = lim;
        cur_dir    = dir;
        chk_en     = 1'b1;
        check("load_strobe", bus.Load, 1);
        check("busy_at_load", bus.Busy, 1);
        if (inject) begin
            bus.Start  = 1'b1;
            bus.Preset = ~pre;
            bus.Limit  = ~lim;
            bus.Dir    = ~dir;
            bus.Rep    = ~rep;
        end
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        check("q_after_load", cnt_q, pre);
        if (!rep) begin
            while (cyc < e0 + n + 2) begin @(posedge Clk); #1; end
        end else begin
            while (cyc < es - 1) begin @(posedge Clk); #1; end
            bus.Stop = 1'b1;
            @(posedge Clk); #1;
            bus.Stop = 1'b0;
            check("busy_after_stop", bus.Busy, 0);
            check("passes_after_stop", bus.Passes, fin);
            @(negedge Clk);
            check("no_done_after_stop", bus.Done, 0);
        end
    endtask

    logic [7:0] rp, rl, off;
    logic       rd;

    initial begin
        bus.Start  = 1'b0;
        bus.Stop   = 1'b0;
        bus.Dir    = 1'b0;
        bus.Rep    = 1'b0;
        bus.Preset = 8'd0;
        bus.Limit  = 8'd0;
        #12;
        check("rst_load", bus.Load, 0);
        check("rst_e", bus.E, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_passes", bus.Passes, 0);
        check("rst_in", bus.In, 0);
        check("rst_d", bus.D, 0);
        #10 Rst_n = 1'b1;

        run(8'd10, 8'd15, 1'b1, 1'b0, 0, 1'b0);   // up run
        run(8'd2, 8'd254, 1'b0, 1'b0, 0, 1'b0);   // down through wrap
        run(8'd77, 8'd77, 1'b1, 1'b0, 0, 1'b0);   // zero steps
        run(8'd0, 8'd3, 1'b1, 1'b1, 17, 1'b0);    // auto-reload, stop after 3 passes
        run(8'd40, 8'd50, 1'b1, 1'b0, 0, 1'b1);   // Start while busy ignored
        run(8'd5, 8'd5, 1'b1, 1'b1, 521, 1'b0);   // Passes saturation

        for (int i = 0; i < 12; i++) begin
            rp = 8'($urandom);
            rl = 8'($urandom);
            rd = 1'($urandom);
            run(rp, rl, rd, 1'b0, 0, 1'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            rp  = 8'($urandom);
            rd  = 1'($urandom);
            off = 8'($urandom_range(0, 5));
            rl  = rd ? rp + off : rp - off;
            run(rp, rl, rd, 1'b1, $urandom_range(3, 4 * (int'(off) + 2)), 1'($urandom));
        end

        // Async reset mid-run with a non-zero pass count.
        @(posedge Clk); #1;
        bus.Start  = 1'b1;
        bus.Preset = 8'd0;
        bus.Limit  = 8'd1;
        bus.Dir    = 1'b1;
        bus.Rep    = 1'b1;
        cur_preset = 8'd0;
        cur_limit  = 8'd1;
        cur_dir    = 1'b1;
        for (int p = 1; p <= 3; p++) pass_q.push_back('{cyc + 1 + 3 * p, 8'(p)});
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (10) @(posedge Clk);
        #2;
        check("passes_before_rst", bus.Passes, 3);
        Rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        check("arst_load", bus.Load, 0);
        check("arst_e", bus.E, 0);
        check("arst_busy", bus.Busy, 0);
        check("arst_done", bus.Done, 0);
        check("arst_passes", bus.Passes, 0);
        check("arst_in", bus.In, 0);
        check("pending_before_rst", pass_q.size(), 0);
        pass_q.delete();
        done_q.delete();
        #20 Rst_n = 1'b1;

        run(8'd100, 8'd97, 1'b0, 1'b0, 0, 1'b0);  // restart after reset
        repeat (3) @(posedge Clk);
        check("pass_q_left", pass_q.size(), 0);
        check("done_q_left", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
